// File: rtl/fetch_pkg.sv
// Types shared by the fetch stage and the fetch/decode bundle queue.
package fetch_pkg;
  localparam int PC_WIDTH = 16;
  localparam int LANES    = 4;
  localparam int BUNDLE_W = LANES * PC_WIDTH;

  typedef struct packed {
    logic [BUNDLE_W-1:0] pc;
    logic [BUNDLE_W-1:0] inst;
    logic [BUNDLE_W-1:0] recv_pc;
    logic [LANES-1:0]    pred;
  } bundle_t;
endpackage

// File: rtl/fdq_bundle_ram.sv
// DEPTH x bundle register file: one write port, one asynchronous read port, no reset.
module fdq_bundle_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  bundle_t       wdata,
  input  logic [AW-1:0] raddr,
  output bundle_t       rdata
);
  bundle_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_decode_queue.sv
// Bundle queue between 4-wide fetch and decode: show-ahead head, registered
// stall with one-entry skid, flush on mispredict, sticky overflow flag.
module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fet_vld,
  input  logic [BUNDLE_W-1:0] fet_pc,
  input  logic [BUNDLE_W-1:0] fet_inst,
  input  logic [BUNDLE_W-1:0] fet_recv_pc,
  input  logic [LANES-1:0]    fet_pred,
  input  logic                has_mispredict,
  input  logic                dec_rdy,
  output logic                stall_fetch,
  output logic                dec_vld,
  output logic [BUNDLE_W-1:0] dec_pc,
  output logic [BUNDLE_W-1:0] dec_inst,
  output logic [BUNDLE_W-1:0] dec_recv_pc,
  output logic [LANES-1:0]    dec_pred,
  output logic                err_overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop, full, empty;
  bundle_t       wdata, rdata;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = dec_vld & dec_rdy & ~has_mispredict;
  // A full queue still accepts when the head leaves the same cycle.
  assign push  = fet_vld & ~has_mispredict & (~full | pop);

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  assign wdata = '{pc: fet_pc, inst: fet_inst, recv_pc: fet_recv_pc, pred: fet_pred};

  fdq_bundle_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      stall_fetch  <= 1'b0;
      err_overflow <= 1'b0;
    end else if (has_mispredict) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      stall_fetch <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      // Raise one entry early so the bundle in flight when stall lands still fits.
      stall_fetch <= (count_next >= (AW+1)'(DEPTH - 1));
      if (fet_vld && full && !pop) err_overflow <= 1'b1;
    end
  end

  assign dec_vld     = ~empty;
  assign dec_pc      = empty ? '0 : rdata.pc;
  assign dec_inst    = empty ? '0 : rdata.inst;
  assign dec_recv_pc = empty ? '0 : rdata.recv_pc;
  assign dec_pred    = empty ? '0 : rdata.pred;
endmodule
